clk_div_ctrl: RTL and testbench

//  Run-time controller for the ref_clock-derived video/sample clock divider.

---
 rtl/clk_div_ctrl.sv | 135 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: glitch-free run-time divider for the video/sample clock.
// Start/stop and ratio changes only land on period boundaries.
module clk_div_ctrl #(
   parameter int          CNT_W        = 8,
   parameter int unsigned DEFAULT_HALF = 5
) (
   input  logic             ref_clock,
   input  logic             reset,
   input  logic             run,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_half_div,
   output logic             cfg_ready,
   output logic             cfg_applied,
   output logic             clk_out,
   output logic             rise_stb,
   output logic             active,
   output logic [CNT_W-1:0] half_active
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      STOP_PEND = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEFH = CNT_W'(DEFAULT_HALF);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             pend_vld;
   logic [CNT_W-1:0] pend_val;

   logic             acc;
   logic [CNT_W-1:0] cfg_clamp;
   logic             term;
   logic             fall_term;
   logic             do_apply;
   logic [CNT_W-1:0] apply_val;

   // Handshake, clamping and period-boundary detection.
   always_comb begin
      acc       = cfg_valid & cfg_ready;
      cfg_clamp = (cfg_half_div == '0) ? ONE : cfg_half_div;
      term      = (cnt == (half_active - ONE));
      fall_term = term & clk_out & (state != IDLE);
      apply_val = pend_vld ? pend_val : cfg_clamp;
      do_apply  = 1'b0;
      if (state == IDLE)
         do_apply = pend_vld;
      else if (fall_term)
         do_apply = pend_vld | acc;
   end

   // Controller FSM with all outputs registered.
   always_ff @(posedge ref_clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         clk_out     <= 1'b0;
         rise_stb    <= 1'b0;
         cfg_applied <= 1'b0;
         active      <= 1'b0;
         half_active <= DEFH;
         pend_vld    <= 1'b0;
         pend_val    <= '0;
         cfg_ready   <= 1'b1;
      end else begin
         rise_stb    <= 1'b0;
         cfg_applied <= 1'b0;

         if (do_apply) begin
            half_active <= apply_val;
            cfg_applied <= 1'b1;
            pend_vld    <= 1'b0;
            cfg_ready   <= 1'b1;
         end else if (acc) begin
            pend_vld  <= 1'b1;
            pend_val  <= cfg_clamp;
            cfg_ready <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               cnt     <= '0;
               clk_out <= 1'b0;
               if (run) begin
                  state  <= RUN;
                  active <= 1'b1;
               end
            end
            RUN: begin
               if (!run && !clk_out) begin
                  state  <= IDLE;
                  active <= 1'b0;
                  cnt    <= '0;
               end else if (term) begin
                  cnt <= '0;
                  if (clk_out) begin
                     clk_out <= 1'b0;
                     if (!run) begin
                        state  <= IDLE;
                        active <= 1'b0;
                     end
                  end else begin
                     clk_out  <= 1'b1;
                     rise_stb <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + ONE;
                  if (!run)
                     state <= STOP_PEND;
               end
            end
            STOP_PEND: begin
               if (term) begin
                  cnt     <= '0;
                  clk_out <= 1'b0;
                  state   <= IDLE;
                  active  <= 1'b0;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            default: begin
               state   <= IDLE;
               active  <= 1'b0;
               cnt     <= '0;
               clk_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed bench for the divider controller.
// Expected event times are queued when stimulus is driven.
module tb_clk_div_ctrl;

   logic       ref_clock = 1'b0;
   logic       reset;
   logic       run;
   logic       cfg_valid;
   logic [7:0] cfg_half_div;
   logic       cfg_ready;
   logic       cfg_applied;
   logic       clk_out;
   logic       rise_stb;
   logic       active;
   logic [7:0] half_active;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int exp_q[$];

   clk_div_ctrl #(.CNT_W(8), .DEFAULT_HALF(5)) dut (
      .ref_clock    (ref_clock),
      .reset        (reset),
      .run          (run),
      .cfg_valid    (cfg_valid),
      .cfg_half_div (cfg_half_div),
      .cfg_ready    (cfg_ready),
      .cfg_applied  (cfg_applied),
      .clk_out      (clk_out),
      .rise_stb     (rise_stb),
      .active       (active),
      .half_active  (half_active)
   );

   always #5 ref_clock = ~ref_clock;

   always @(posedge ref_clock) cyc <= cyc + 1;

   task automatic tick();
      @(negedge ref_clock);
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input int v);
      exp_q.push_back(v);
   endtask

   task automatic sb_pop(input string tag, input int obs);
      int e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: got %0d expected <empty queue>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         chk(tag, obs, e);
      end
   endtask

   // sel: 0 rise_stb, 1 clk_out low, 2 cfg_applied, 3 clk_out high
   task automatic wait_evt(input int sel, input int budget, output int t);
      logic hit;
      t = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         case (sel)
            0: hit = rise_stb;
            1: hit = !clk_out;
            2: hit = cfg_applied;
            default: hit = clk_out;
         endcase
         if (hit === 1'b1) begin
            t = cyc;
            break;
         end
      end
   endtask

   initial begin
      int t, t0, tr, ta;
      reset = 1'b1;
      run = 1'b0;
      cfg_valid = 1'b0;
      cfg_half_div = 8'd0;
      tick();
      tick();
      chk("rst_clk_out", int'(clk_out), 0);
      chk("rst_rise_stb", int'(rise_stb), 0);
      chk("rst_applied", int'(cfg_applied), 0);
      chk("rst_active", int'(active), 0);
      chk("rst_half", int'(half_active), 5);
      chk("rst_ready", int'(cfg_ready), 1);
      reset = 1'b0;
      tick();

      // divide-by-10 from a clean start
      run = 1'b1;
      tick();
      t0 = cyc;
      chk("run_active", int'(active), 1);
      chk("run_clk_low", int'(clk_out), 0);
      sb_push(t0 + 5);
      wait_evt(0, 50, t);
      sb_pop("first_rise", t);
      chk("rise_clk_high", int'(clk_out), 1);
      tr = t;
      sb_push(tr + 5);
      wait_evt(1, 50, t);
      sb_pop("high5", t);
      sb_push(tr + 10);
      wait_evt(0, 50, t);
      sb_pop("period10", t);
      tr = t;

      // ratio change offered in the high phase
      cfg_valid = 1'b1;
      cfg_half_div = 8'd3;
      tick();
      cfg_valid = 1'b0;
      chk("ready_low_pend", int'(cfg_ready), 0);
      chk("half_unchanged", int'(half_active), 5);
      sb_push(tr + 5);
      wait_evt(2, 50, t);
      sb_pop("apply3_at_fall", t);
      chk("apply3_clk_low", int'(clk_out), 0);
      chk("apply3_half", int'(half_active), 3);
      chk("apply3_ready", int'(cfg_ready), 1);
      sb_push(t + 3);
      wait_evt(0, 50, t);
      sb_pop("low3", t);
      tr = t;
      sb_push(tr + 6);
      wait_evt(0, 50, t);
      sb_pop("period6", t);
      tr = t;

      // back-to-back configs: second stalls until first lands
      cfg_valid = 1'b1;
      cfg_half_div = 8'd7;
      tick();
      cfg_half_div = 8'd4;
      chk("stall_ready", int'(cfg_ready), 0);
      sb_push(tr + 3);
      wait_evt(2, 50, t);
      sb_pop("apply7", t);
      chk("apply7_half", int'(half_active), 7);
      ta = t;
      tick();
      cfg_valid = 1'b0;
      chk("ready_after4", int'(cfg_ready), 0);
      sb_push(ta + 14);
      wait_evt(2, 60, t);
      sb_pop("apply4_one_period", t);
      chk("apply4_half", int'(half_active), 4);

      // stop in the high phase completes the high phase
      sb_push(t + 4);
      wait_evt(0, 50, t);
      sb_pop("rise4", t);
      tr = t;
      tick();
      run = 1'b0;
      sb_push(tr + 4);
      wait_evt(1, 50, t);
      sb_pop("stop_full_high", t);
      chk("idle_after_stop", int'(active), 0);
      sb_push(-1);
      wait_evt(0, 20, t);
      sb_pop("no_runt", t);

      // zero is clamped to one: divide-by-2
      cfg_valid = 1'b1;
      cfg_half_div = 8'd0;
      tick();
      cfg_valid = 1'b0;
      chk("idle_ready_low", int'(cfg_ready), 0);
      tick();
      chk("idle_apply_next", int'(cfg_applied), 1);
      chk("clamp_half", int'(half_active), 1);
      run = 1'b1;
      tick();
      t0 = cyc;
      sb_push(t0 + 1);
      wait_evt(0, 20, t);
      sb_pop("div2_first", t);
      sb_push(t + 2);
      wait_evt(0, 20, t);
      sb_pop("div2_a", t);
      sb_push(t + 2);
      wait_evt(0, 20, t);
      sb_pop("div2_b", t);

      // reset in the high phase with a pending value
      tick();
      cfg_valid = 1'b1;
      cfg_half_div = 8'd9;
      tick();
      cfg_valid = 1'b0;
      chk("pre_rst_pend", int'(cfg_ready), 0);
      chk("pre_rst_high", int'(clk_out), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_clk", int'(clk_out), 0);
      chk("mid_rst_half", int'(half_active), 5);
      chk("mid_rst_ready", int'(cfg_ready), 1);
      chk("mid_rst_active", int'(active), 0);
      run = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      tick();
      tick();
      chk("pend_dropped", int'(half_active), 5);
      chk("no_apply_post", int'(cfg_applied), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
